hazard_ctrl: RTL and testbench

Hazard and forwarding controller for the 5-stage MIPS pipeline. It sits directly downstream of the D-stage instruction decoder and consumes that decoder's per-instruction Tuse flags, Tnew, destination register and RegWrite. It keeps its own shadow pipeline of destination/Tnew/write-enable for the E, M and W stages. From that it drives the stall (PC/IF-ID freeze, ID-EX bubble) and the D-stage operand forwarding selects.

---
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// D-stage hazard and forwarding control for a 5-stage MIPS pipeline.
// Keeps a shadow E/M/W copy of dest/Tnew/we, and derives stall and the D operand bypass selects from it.

module hazard_opnd #(
  parameter int TNEW_W = 3
) (
  input  logic [4:0]        r,
  input  logic [2:0]        tuse,    // {tuse2, tuse1, tuse0}
  input  logic [4:0]        e_a3,
  input  logic [TNEW_W-1:0] e_tnew,
  input  logic              e_we,
  input  logic [4:0]        m_a3,
  input  logic [TNEW_W-1:0] m_tnew,
  input  logic              m_we,
  input  logic [4:0]        w_a3,
  input  logic              w_we,
  output logic              stall,
  output logic [1:0]        fwd
);
  logic              e_hit, m_hit, w_hit, use_any;
  logic [TNEW_W-1:0] tuse_v;

  assign e_hit   = e_we && (e_a3 == r) && (r != 5'd0);
  assign m_hit   = m_we && (m_a3 == r) && (r != 5'd0);
  assign w_hit   = w_we && (w_a3 == r) && (r != 5'd0);
  assign use_any = |tuse;

  // Lowest Tuse wins; no flag at all means the operand is never checked.
  always_comb begin
    tuse_v = TNEW_W'(2);
    if (tuse[0])      tuse_v = TNEW_W'(0);
    else if (tuse[1]) tuse_v = TNEW_W'(1);
  end

  assign stall = use_any && ((e_hit && (e_tnew > tuse_v)) ||
                             (m_hit && (m_tnew > tuse_v)));

  always_comb begin
    fwd = 2'd0;
    if (e_hit && (e_tnew == '0))      fwd = 2'd1;
    else if (m_hit && (m_tnew == '0)) fwd = 2'd2;
    else if (w_hit)                   fwd = 2'd3;
  end
endmodule

module hazard_ctrl #(
  parameter int TNEW_W = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        d_rs,
  input  logic [4:0]        d_rt,
  input  logic              tuse_rs0,
  input  logic              tuse_rs1,
  input  logic              tuse_rt0,
  input  logic              tuse_rt1,
  input  logic              tuse_rt2,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic [4:0]        d_a3,
  input  logic              d_regwrite,
  output logic              stall,
  output logic              pc_en,
  output logic              fd_en,
  output logic              de_clr,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int STAGES  = 2;
  localparam int NUM_OPS = 2;  // 0 = rs, 1 = rt

  // Write-enable shift register: [0]=E, [1]=M, [2]=W.
  logic [STAGES:0]   vld_pipe;
  logic [4:0]        e_a3, m_a3, w_a3;
  logic [TNEW_W-1:0] e_tnew, m_tnew;

  logic [NUM_OPS-1:0][4:0] op_reg;
  logic [NUM_OPS-1:0][2:0] op_tuse;
  logic [NUM_OPS-1:0][1:0] op_fwd;
  logic [NUM_OPS-1:0]      op_stall;

  assign op_reg[0]  = d_rs;
  assign op_reg[1]  = d_rt;
  assign op_tuse[0] = {1'b0, tuse_rs1, tuse_rs0};
  assign op_tuse[1] = {tuse_rt2, tuse_rt1, tuse_rt0};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    hazard_opnd #(.TNEW_W(TNEW_W)) u_op (
      .r      (op_reg[i]),
      .tuse   (op_tuse[i]),
      .e_a3   (e_a3),
      .e_tnew (e_tnew),
      .e_we   (vld_pipe[0]),
      .m_a3   (m_a3),
      .m_tnew (m_tnew),
      .m_we   (vld_pipe[1]),
      .w_a3   (w_a3),
      .w_we   (vld_pipe[2]),
      .stall  (op_stall[i]),
      .fwd    (op_fwd[i])
    );
  end

  assign stall    = |op_stall;
  assign pc_en    = ~stall;
  assign fd_en    = ~stall;
  assign de_clr   = stall;
  assign fwd_rs_d = op_fwd[0];
  assign fwd_rt_d = op_fwd[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      e_a3      <= '0;
      e_tnew    <= '0;
      m_a3      <= '0;
      m_tnew    <= '0;
      w_a3      <= '0;
      stall_cnt <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], d_regwrite & ~stall};
      e_a3     <= stall ? 5'd0 : d_a3;
      e_tnew   <= stall ? '0 : d_tnew;
      m_a3     <= e_a3;
      // Tnew decays toward zero and must not wrap past it.
      m_tnew   <= (e_tnew == '0) ? '0 : e_tnew - TNEW_W'(1);
      w_a3     <= m_a3;
      if (stall) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: classic MIPS hazard sequences with hand-derived stall/forward results.

module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs, d_rt, d_a3;
  logic        tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, tuse_rt2;
  logic [2:0]  d_tnew;
  logic        d_regwrite;
  logic        stall, pc_en, fd_en, de_clr;
  logic [1:0]  fwd_rs_d, fwd_rt_d;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] RS0  = 5'b00001;
  localparam logic [4:0] RS1  = 5'b00010;
  localparam logic [4:0] RT0  = 5'b00100;
  localparam logic [4:0] RT1  = 5'b01000;
  localparam logic [4:0] RT2  = 5'b10000;

  hazard_ctrl #(.TNEW_W(3), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
    .tuse_rs0(tuse_rs0), .tuse_rs1(tuse_rs1),
    .tuse_rt0(tuse_rt0), .tuse_rt1(tuse_rt1), .tuse_rt2(tuse_rt2),
    .d_tnew(d_tnew), .d_a3(d_a3), .d_regwrite(d_regwrite),
    .stall(stall), .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, exp});
    chk({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, ~exp});
    chk({tag, ".fd_en"}, {31'd0, fd_en}, {31'd0, ~exp});
    chk({tag, ".de_clr"}, {31'd0, de_clr}, {31'd0, exp});
  endtask

  // Drive the D-stage instruction on a falling edge, settle, then let checks run.
  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] f,
                       input logic [2:0] tnew, input logic [4:0] a3, input logic we);
    d_rs = rs; d_rt = rt;
    {tuse_rt2, tuse_rt1, tuse_rt0, tuse_rs1, tuse_rs0} = f;
    d_tnew = tnew; d_a3 = a3; d_regwrite = we;
    #1;
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_d(5'd0, 5'd0, NONE, 3'd0, 5'd0, 1'b0);
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_d(5'd0, 5'd0, NONE, 3'd0, 5'd0, 1'b0);
    next_cyc();
    chk_stall("rst", 1'b0);
    chk("rst.fwd_rs", {30'd0, fwd_rs_d}, 32'd0);
    chk("rst.fwd_rt", {30'd0, fwd_rt_d}, 32'd0);
    chk("rst.cnt", stall_cnt, 32'd0);
    reset = 1'b0;

    // lw $1,0($0) ; addu $2,$1,$3
    set_d(5'd0, 5'd0, RS1, 3'd2, 5'd1, 1'b1);
    chk_stall("lw_addu.c1", 1'b0);
    next_cyc();
    set_d(5'd1, 5'd3, RS1 | RT1, 3'd1, 5'd2, 1'b1);
    chk_stall("lw_addu.c2", 1'b1);
    next_cyc();
    chk_stall("lw_addu.c3", 1'b0);
    chk("lw_addu.c3.fwd_rs", {30'd0, fwd_rs_d}, 32'd0);
    chk("lw_addu.c3.cnt", stall_cnt, 32'd1);
    next_cyc();
    set_d(5'd1, 5'd2, NONE, 3'd0, 5'd0, 1'b0);
    chk("lw_addu.c4.fwd_rs_w", {30'd0, fwd_rs_d}, 32'd3);
    chk("lw_addu.c4.fwd_rt_e_busy", {30'd0, fwd_rt_d}, 32'd0);
    next_cyc();
    set_d(5'd2, 5'd0, NONE, 3'd0, 5'd0, 1'b0);
    chk("lw_addu.c5.fwd_rs_m", {30'd0, fwd_rs_d}, 32'd2);
    chk("lw_addu.c5.cnt", stall_cnt, 32'd1);

    // lw $1 ; beq $1,$0 : two-cycle stall
    do_reset();
    set_d(5'd0, 5'd0, RS1, 3'd2, 5'd1, 1'b1);
    next_cyc();
    set_d(5'd1, 5'd0, RS0 | RT0, 3'd0, 5'd0, 1'b0);
    chk_stall("lw_beq.c2", 1'b1);
    next_cyc();
    chk_stall("lw_beq.c3", 1'b1);
    chk("lw_beq.c3.fwd_rs", {30'd0, fwd_rs_d}, 32'd0);
    next_cyc();
    chk_stall("lw_beq.c4", 1'b0);
    chk("lw_beq.c4.fwd_rs", {30'd0, fwd_rs_d}, 32'd3);
    chk("lw_beq.c4.fwd_rt", {30'd0, fwd_rt_d}, 32'd0);
    chk("lw_beq.c4.cnt", stall_cnt, 32'd2);

    // ori $5 ; sw $4,0($5) ; sw again with ori in M
    do_reset();
    set_d(5'd0, 5'd0, RS1, 3'd1, 5'd5, 1'b1);
    next_cyc();
    set_d(5'd4, 5'd5, RS1 | RT2, 3'd0, 5'd0, 1'b0);
    chk_stall("ori_sw.c2", 1'b0);
    chk("ori_sw.c2.fwd_rt", {30'd0, fwd_rt_d}, 32'd0);
    next_cyc();
    chk_stall("ori_sw.c3", 1'b0);
    chk("ori_sw.c3.fwd_rt", {30'd0, fwd_rt_d}, 32'd2);

    // jal ; jr $31, then a Tuse=1 read with jal in M (Tnew must stay 0)
    do_reset();
    set_d(5'd0, 5'd0, NONE, 3'd0, 5'd31, 1'b1);
    next_cyc();
    set_d(5'd31, 5'd0, RS0, 3'd0, 5'd0, 1'b0);
    chk_stall("jal_jr", 1'b0);
    chk("jal_jr.fwd_rs", {30'd0, fwd_rs_d}, 32'd1);
    next_cyc();
    set_d(5'd31, 5'd31, RS1 | RT1, 3'd1, 5'd3, 1'b1);
    chk_stall("jal_m.sat", 1'b0);
    chk("jal_m.fwd_rs", {30'd0, fwd_rs_d}, 32'd2);
    chk("jal_m.fwd_rt", {30'd0, fwd_rt_d}, 32'd2);

    // lw $7 ; addu $8,$7,$7 : both operands hazard, one stall cycle
    do_reset();
    set_d(5'd0, 5'd0, RS1, 3'd2, 5'd7, 1'b1);
    next_cyc();
    set_d(5'd7, 5'd7, RS1 | RT1, 3'd1, 5'd8, 1'b1);
    chk_stall("dual.c2", 1'b1);
    next_cyc();
    chk_stall("dual.c3", 1'b0);
    chk("dual.c3.cnt", stall_cnt, 32'd1);

    // write to $0 with Tnew=2, then read $0 at Tuse=0
    do_reset();
    set_d(5'd0, 5'd0, RS1, 3'd2, 5'd0, 1'b1);
    next_cyc();
    set_d(5'd0, 5'd0, RS0 | RT0, 3'd0, 5'd0, 1'b0);
    chk_stall("zero_reg", 1'b0);
    chk("zero_reg.fwd_rs", {30'd0, fwd_rs_d}, 32'd0);
    chk("zero_reg.fwd_rt", {30'd0, fwd_rt_d}, 32'd0);

    // Reset mid-stall takes effect without a clock edge
    do_reset();
    set_d(5'd0, 5'd0, RS1, 3'd2, 5'd9, 1'b1);
    next_cyc();
    set_d(5'd9, 5'd9, RS0 | RT0, 3'd0, 5'd0, 1'b0);
    next_cyc();
    chk_stall("midrst.pre", 1'b1);
    chk("midrst.pre.cnt", stall_cnt, 32'd1);
    reset = 1'b1;
    #1;
    chk_stall("midrst.post", 1'b0);
    chk("midrst.post.fwd_rs", {30'd0, fwd_rs_d}, 32'd0);
    chk("midrst.post.fwd_rt", {30'd0, fwd_rt_d}, 32'd0);
    chk("midrst.post.cnt", stall_cnt, 32'd0);
    next_cyc();
    chk("midrst.held.cnt", stall_cnt, 32'd0);
    chk_stall("midrst.held", 1'b0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
